sipo_word_assembler: RTL and testbench

- Parametrised serial-in/parallel-out word assembler for the serial-to-parallel interface.
- Successor to the fixed 5-to-32 select decoder. A bit-position counter drives a registered one-hot write-enable decoder of width 2**SEL_W, which steers each incoming serial bit into an assembly register.
- Completed words go into an output holding register with a valid/ready handshake. Supports LSB-first or MSB-first bit order, a frame resync input and backpressure.

---
 rtl/sipo_pkg.sv | 16 +
 rtl/onehot_decoder.sv | 15 +
 rtl/sipo_word_assembler.sv | 85 ++++++++
 tb/tb_sipo_word_assembler.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in/parallel-out word assembler:
// default index width, derived word width and serial bit-order encoding.
package sipo_pkg;

  localparam int SEL_W_DEF = 5;

  typedef enum logic {
    ORDER_LSB = 1'b0,
    ORDER_MSB = 1'b1
  } bit_order_e;

  function automatic int data_w(input int sel_w);
    return 1 << sel_w;
  endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Combinational binary-to-one-hot decoder; SEL_W-bit select drives a
// 2**SEL_W-bit vector with exactly one bit set.
module onehot_decoder #(
  parameter int SEL_W = 5
) (
  input  logic [SEL_W-1:0]      sel,
  output logic [(2**SEL_W)-1:0] onehot
);

  always_comb begin
    onehot      = '0;
    onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/sipo_word_assembler.sv
// Serial-in/parallel-out word assembler: steers serial bits into an assembly
// register via a registered one-hot enable, hands full words out on valid/ready.
module sipo_word_assembler
  import sipo_pkg::*;
#(
  parameter int SEL_W     = SEL_W_DEF,
  parameter int MSB_FIRST = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  SIN,
  input  logic                  SIN_VALID,
  output logic                  SIN_READY,
  input  logic                  SYNC,
  output logic [(2**SEL_W)-1:0] POUT,
  output logic                  POUT_VALID,
  input  logic                  POUT_READY,
  output logic [SEL_W-1:0]      BIT_IDX,
  output logic [(2**SEL_W)-1:0] DEC_OUT
);

  localparam int DATA_W = data_w(SEL_W);
  localparam bit_order_e ORDER = (MSB_FIRST != 0) ? ORDER_MSB : ORDER_LSB;
  localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0] DEC_RST =
    (ORDER == ORDER_MSB) ? {1'b1, {(DATA_W-1){1'b0}}} : DATA_W'(1);

  logic [SEL_W-1:0]  idx_p0, idx_nxt, pos_nxt;
  logic [DATA_W-1:0] asm_p0, pout_p0, dec_p0, dec_nxt, merged;
  logic              vld_p0, last, rdy, acc, complete, consume;

  // Stage 0: accept decision, bit merge and next-position decode
  assign last     = (idx_p0 == IDX_LAST);
  assign rdy      = !(last && vld_p0 && !POUT_READY);
  assign acc      = SIN_VALID && rdy;
  // A bit presented together with SYNC is dropped, even on the last position
  assign complete = acc && last && !SYNC;
  assign consume  = vld_p0 && POUT_READY;
  assign merged   = (asm_p0 & ~dec_p0) | (dec_p0 & {DATA_W{SIN}});

  always_comb begin
    idx_nxt = idx_p0;
    if (SYNC)
      idx_nxt = '0;
    else if (acc)
      idx_nxt = idx_p0 + SEL_W'(1);
    pos_nxt = (ORDER == ORDER_MSB) ? ~idx_nxt : idx_nxt;
  end

  onehot_decoder #(.SEL_W(SEL_W)) u_dec (
    .sel    (pos_nxt),
    .onehot (dec_nxt)
  );

  // Stage 0 -> registered state: index, enable, assembly and output hold
  always_ff @(posedge CLK) begin
    if (RST) begin
      idx_p0  <= '0;
      dec_p0  <= DEC_RST;
      asm_p0  <= '0;
      pout_p0 <= '0;
      vld_p0  <= 1'b0;
    end else begin
      idx_p0 <= idx_nxt;
      dec_p0 <= dec_nxt;
      if (SYNC || complete)
        asm_p0 <= '0;
      else if (acc)
        asm_p0 <= merged;
      if (complete)
        pout_p0 <= merged;
      if (complete)
        vld_p0 <= 1'b1;
      else if (consume)
        vld_p0 <= 1'b0;
    end
  end

  assign SIN_READY  = rdy;
  assign POUT       = pout_p0;
  assign POUT_VALID = vld_p0;
  assign BIT_IDX    = idx_p0;
  assign DEC_OUT    = dec_p0;

endmodule

// File: tb/tb_sipo_word_assembler.sv
// Bench for sipo_word_assembler: three instances (32-bit LSB-first, 32-bit
// MSB-first, 8-bit LSB-first) driven from one shared set of inputs.
module tb_sipo_word_assembler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, sin, sin_valid, sync, pout_ready;

  logic        rdy_l, vld_l, rdy_m, vld_m, rdy_b, vld_b;
  logic [31:0] pout_l, dec_l, pout_m, dec_m;
  logic [4:0]  idx_l, idx_m;
  logic [7:0]  pout_b, dec_b;
  logic [2:0]  idx_b;

  sipo_word_assembler #(.SEL_W(5), .MSB_FIRST(0)) u_lsb (
    .CLK(clk), .RST(rst), .SIN(sin), .SIN_VALID(sin_valid), .SIN_READY(rdy_l),
    .SYNC(sync), .POUT(pout_l), .POUT_VALID(vld_l), .POUT_READY(pout_ready),
    .BIT_IDX(idx_l), .DEC_OUT(dec_l)
  );

  sipo_word_assembler #(.SEL_W(5), .MSB_FIRST(1)) u_msb (
    .CLK(clk), .RST(rst), .SIN(sin), .SIN_VALID(sin_valid), .SIN_READY(rdy_m),
    .SYNC(sync), .POUT(pout_m), .POUT_VALID(vld_m), .POUT_READY(pout_ready),
    .BIT_IDX(idx_m), .DEC_OUT(dec_m)
  );

  sipo_word_assembler #(.SEL_W(3), .MSB_FIRST(0)) u_byte (
    .CLK(clk), .RST(rst), .SIN(sin), .SIN_VALID(sin_valid), .SIN_READY(rdy_b),
    .SYNC(sync), .POUT(pout_b), .POUT_VALID(vld_b), .POUT_READY(pout_ready),
    .BIT_IDX(idx_b), .DEC_OUT(dec_b)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic       sv;
    logic       sin;
    logic [2:0] eidx;
    logic [7:0] edec;
    logic       evld;
    logic [7:0] epout;
  } vec_t;

  vec_t tbl[32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; sin = 1'b0; sin_valid = 1'b0; sync = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic send_word_bits(input logic [31:0] w, input int nbits);
    for (int k = 0; k < nbits; k++) begin
      sin = w[k]; sin_valid = 1'b1;
      step();
    end
    sin_valid = 1'b0;
  endtask

  function automatic logic [31:0] rev32(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = x[31-i];
    return r;
  endfunction

  initial begin
    logic [31:0] w;
    logic        q[$];
    logic        mvld, exp_rdy, done, consume;
    logic [31:0] mword, word;

    rst = 1'b1; sin = 1'b0; sin_valid = 1'b0; sync = 1'b0; pout_ready = 1'b1;

    // Reset state
    do_reset();
    chk("rst_pout", pout_l, 32'h0);
    chk("rst_vld", vld_l, 1'b0);
    chk("rst_idx", idx_l, 5'd0);
    chk("rst_dec_lsb", dec_l, 32'h0000_0001);
    chk("rst_dec_msb", dec_m, 32'h8000_0000);
    chk("rst_dec_byte", dec_b, 8'h01);
    chk("rst_rdy", rdy_l, 1'b1);

    // Full word, both bit orders
    w = 32'hA5C3_0F81;
    for (int k = 0; k < 32; k++) begin
      sin = w[k]; sin_valid = 1'b1;
      step();
      if (k == 0) begin
        chk("first_dec_msb", dec_m, 32'h4000_0000);
        chk("first_dec_lsb", dec_l, 32'h0000_0002);
        chk("first_idx", idx_l, 5'd1);
      end
      if (k == 30) chk("early_vld", vld_l, 1'b0);
    end
    sin_valid = 1'b0;
    chk("word_vld", vld_l, 1'b1);
    chk("word_pout_lsb", pout_l, 32'hA5C3_0F81);
    chk("word_pout_msb", pout_m, 32'h81F0_C3A5);
    chk("word_rev_model", pout_m, rev32(w));
    chk("word_idx", idx_l, 5'd0);
    chk("word_dec_lsb", dec_l, 32'h0000_0001);
    chk("word_dec_msb", dec_m, 32'h8000_0000);
    step();
    chk("word_consumed", vld_l, 1'b0);

    // Backpressure across two words
    do_reset();
    pout_ready = 1'b0;
    send_word_bits(32'h1111_1111, 32);
    chk("bp_vld1", vld_l, 1'b1);
    chk("bp_pout1", pout_l, 32'h1111_1111);
    send_word_bits(32'h2222_2222, 31);
    chk("bp_idx31", idx_l, 5'd31);
    chk("bp_hold", pout_l, 32'h1111_1111);
    w = 32'h2222_2222;
    sin = w[31]; sin_valid = 1'b1;
    #1;
    chk("bp_rdy_low", rdy_l, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_stall_idx", idx_l, 5'd31);
      chk("bp_stall_pout", pout_l, 32'h1111_1111);
      chk("bp_stall_vld", vld_l, 1'b1);
    end
    pout_ready = 1'b1;
    #1;
    chk("bp_rdy_high", rdy_l, 1'b1);
    step();
    sin_valid = 1'b0;
    chk("bp_pout2", pout_l, 32'h2222_2222);
    chk("bp_vld2", vld_l, 1'b1);
    chk("bp_idx0", idx_l, 5'd0);
    step();
    chk("bp_drain", vld_l, 1'b0);

    // SYNC mid-word, then on the last position
    do_reset();
    pout_ready = 1'b1;
    send_word_bits(32'hFFFF_FFFF, 13);
    chk("sync_idx13", idx_l, 5'd13);
    sin = 1'b1; sin_valid = 1'b1; sync = 1'b1;
    step();
    sync = 1'b0; sin_valid = 1'b0;
    chk("sync_idx0", idx_l, 5'd0);
    chk("sync_no_vld", vld_l, 1'b0);
    send_word_bits(32'hDEAD_BEEF, 31);
    chk("sync_pre_vld", vld_l, 1'b0);
    send_word_bits(32'h0000_0001, 1);
    chk("sync_clean_vld", vld_l, 1'b1);
    chk("sync_clean_pout", pout_l, 32'hDEAD_BEEF);
    send_word_bits(32'h0F0F_0F0F, 31);
    sin = 1'b0; sin_valid = 1'b1; sync = 1'b1;
    step();
    sync = 1'b0; sin_valid = 1'b0;
    chk("sync_last_vld", vld_l, 1'b0);
    chk("sync_last_idx", idx_l, 5'd0);

    // Reset mid-word with a pending word
    do_reset();
    pout_ready = 1'b0;
    send_word_bits(32'h1234_5678, 32);
    send_word_bits(32'hFFFF_FFFF, 20);
    chk("midrst_pre_vld", vld_l, 1'b1);
    chk("midrst_pre_idx", idx_l, 5'd20);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_pout", pout_l, 32'h0);
    chk("midrst_vld", vld_l, 1'b0);
    chk("midrst_idx", idx_l, 5'd0);
    chk("midrst_dec", dec_l, 32'h0000_0001);

    // 8-bit instance, gapped stream 0x3C then 0xFF
    for (int i = 0; i < 32; i++) begin
      int b, n;
      logic [7:0] wd;
      b = i / 2;
      n = i / 2 + 1;
      wd = (b < 8) ? 8'h3C : 8'hFF;
      tbl[i].sv    = (i % 2 == 0);
      tbl[i].sin   = (i % 2 == 0) ? wd[b % 8] : 1'b0;
      tbl[i].eidx  = 3'(n % 8);
      tbl[i].edec  = 8'(1 << (n % 8));
      tbl[i].evld  = (i % 2 == 0) && (n % 8 == 0);
      tbl[i].epout = wd;
    end
    do_reset();
    pout_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      sin_valid = tbl[i].sv;
      sin = tbl[i].sin;
      step();
      chk("byte_idx", idx_b, tbl[i].eidx);
      chk("byte_dec", dec_b, tbl[i].edec);
      chk("byte_vld", vld_b, tbl[i].evld);
      if (tbl[i].evld) chk("byte_pout", pout_b, tbl[i].epout);
    end
    sin_valid = 1'b0;

    // Randomized traffic against a queue-based reference model
    do_reset();
    q.delete();
    mvld = 1'b0;
    mword = '0;
    for (int c = 0; c < 600; c++) begin
      sin        = 1'($urandom);
      sin_valid  = ($urandom % 4) != 0;
      sync       = ($urandom % 25) == 0;
      pout_ready = ($urandom % 3) != 0;
      #1;
      exp_rdy = !(q.size() == 31 && mvld && !pout_ready);
      chk("rnd_rdy", rdy_l, exp_rdy);
      consume = mvld && pout_ready;
      done = 1'b0;
      if (sync) begin
        q.delete();
      end else if (sin_valid && exp_rdy) begin
        q.push_back(sin);
        if (q.size() == 32) begin
          word = '0;
          for (int i = 0; i < 32; i++) word[i] = q[i];
          q.delete();
          done = 1'b1;
        end
      end
      if (done) begin
        mvld = 1'b1;
        mword = word;
      end else if (consume) begin
        mvld = 1'b0;
      end
      step();
      chk("rnd_vld", vld_l, mvld);
      chk("rnd_idx", idx_l, 32'(q.size()));
      if (mvld) begin
        chk("rnd_pout_lsb", pout_l, mword);
        chk("rnd_pout_msb", pout_m, rev32(mword));
      end
    end
    sin_valid = 1'b0;
    sync = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
